// File: rtl/d_cache_wt_pkg.sv
// Shared types for the write-through data cache: FSM states and downstream size codes.
package d_cache_wt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/d_cache_wt_wsize_dec.sv
// Store byte-enable decoder: picks the narrowest legal downstream size and the low address bits.
module dcache_wsize_dec
  import d_cache_wt_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  always_comb begin
    size    = SZ_WORD;
    addr_lo = 2'd0;
    case (wen)
      4'b0001: begin size = SZ_BYTE; addr_lo = 2'd0; end
      4'b0010: begin size = SZ_BYTE; addr_lo = 2'd1; end
      4'b0100: begin size = SZ_BYTE; addr_lo = 2'd2; end
      4'b1000: begin size = SZ_BYTE; addr_lo = 2'd3; end
      4'b0011: begin size = SZ_HALF; addr_lo = 2'd0; end
      4'b1100: begin size = SZ_HALF; addr_lo = 2'd2; end
      // irregular masks fall back to a full-word write
      default: begin size = SZ_WORD; addr_lo = 2'd0; end
    endcase
  end

endmodule

// File: rtl/d_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Load hits return in the same cycle; misses, uncached accesses and stores go downstream and stall.
module d_cache_wt
  import d_cache_wt_pkg::*;
#(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr [LINES];
  logic [31:0]      data_arr [LINES];
  logic [31:0]      data_reg;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic                   is_store, line_match, load_hit, resp_done;
  logic [31:0]            merged;
  logic [1:0]             st_size, st_lo;
  logic                   unused_addr_bits;

  assign idx        = cpu_addr[INDEX_WIDTH+1:2];
  assign tag        = cpu_addr[31:INDEX_WIDTH+2];
  assign is_store   = |cpu_wen;
  assign line_match = ~cpu_uncached & valid[idx] & (tag_arr[idx] == tag);
  // lookup only counts in IDLE so the RESP cycle never re-triggers the same request
  assign load_hit   = cpu_en & ~is_store & line_match & (state == IDLE);
  assign resp_done  = (state == WAIT) & mem_data_ok;
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    merged = data_arr[idx];
    for (int b = 0; b < 4; b++)
      if (cpu_wen[b]) merged[8*b +: 8] = cpu_wdata[8*b +: 8];
  end

  dcache_wsize_dec u_wsize_dec (
    .wen     (cpu_wen),
    .size    (st_size),
    .addr_lo (st_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cpu_en && !load_hit) state_nxt = REQ;
      REQ:  if (mem_addr_ok)         state_nxt = WAIT;
      WAIT: if (mem_data_ok)         state_nxt = RESP;
      RESP:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = data_arr[idx];
    mem_req   = 1'b0;
    case (state)
      IDLE: cpu_stall = cpu_en & ~load_hit;
      REQ:  begin cpu_stall = 1'b1; mem_req = 1'b1; end
      WAIT: cpu_stall = 1'b1;
      RESP: cpu_rdata = data_reg;
      default: cpu_stall = 1'b0;
    endcase
  end

  assign mem_wr    = is_store;
  assign mem_size  = is_store ? st_size : SZ_WORD;
  assign mem_addr  = {cpu_addr[31:2], (is_store ? st_lo : 2'b00)};
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      data_reg <= '0;
    end else if (resp_done && !is_store) begin
      data_reg <= mem_rdata;
      if (!cpu_uncached) valid[idx] <= 1'b1;
    end
  end

  // tag/data need no reset: an entry is only read once its valid bit is set
  always_ff @(posedge clk) begin
    if (!rst && resp_done) begin
      if (!is_store && !cpu_uncached) begin
        tag_arr[idx]  <= tag;
        data_arr[idx] <= mem_rdata;
      end else if (is_store && line_match) begin
        data_arr[idx] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_d_cache_wt.sv
// Directed bench for d_cache_wt with a small SRAM-bus responder and hand-computed expectations.
module tb_d_cache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_uncached;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_cache_wt #(.INDEX_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_uncached(cpu_uncached), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one access starting at a negedge; answers requests after dly waiting cycles
  // and returns data_ok one cycle after acceptance.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic unc, input int dly, input logic [31:0] resp,
                        output logic [31:0] rd, output int nreq, output logic [31:0] maddr,
                        output logic [1:0] msize, output logic mwr, output logic stable);
    int  wait_req;
    logic pend, seen, done;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_uncached = unc;
    nreq = 0; wait_req = 0; pend = 1'b0; seen = 1'b0; done = 1'b0; stable = 1'b1;
    rd = '0; maddr = '0; msize = '0; mwr = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (pend) begin
        mem_data_ok = 1'b1;
        mem_rdata   = resp;
        pend        = 1'b0;
      end
      #1;
      if (!cpu_stall) begin
        rd   = cpu_rdata;
        done = 1'b1;
      end else if (mem_req) begin
        if (!seen) begin
          seen = 1'b1; maddr = mem_addr; msize = mem_size; mwr = mem_wr;
        end else if (mem_addr !== maddr || mem_size !== msize || mem_wr !== mwr) begin
          stable = 1'b0;
        end
        if (wait_req >= dly) begin
          mem_addr_ok = 1'b1; pend = 1'b1; nreq++; wait_req = 0;
        end else begin
          wait_req++;
        end
      end
      if (!done) @(negedge clk);
    end
    chk("access_timeout", {31'd0, done}, 32'd1);
    @(negedge clk);
    cpu_en = 1'b0; cpu_wen = 4'd0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] rd, maddr;
  logic [1:0]  msize;
  logic        mwr, stable;
  int          nreq;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = '0; cpu_wdata = '0;
    cpu_uncached = 1'b0; mem_rdata = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_req",   {31'd0, mem_req},   32'd0);
    @(negedge clk);

    // 1: cold miss then hit
    access(4'b0000, 32'h0000_0100, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, rd, nreq, maddr, msize, mwr, stable);
    chk("t1_miss_nreq", nreq, 32'd1);
    chk("t1_miss_addr", maddr, 32'h0000_0100);
    chk("t1_miss_size", {30'd0, msize}, 32'd2);
    chk("t1_miss_wr",   {31'd0, mwr}, 32'd0);
    chk("t1_miss_rd",   rd, 32'hDEAD_BEEF);
    access(4'b0000, 32'h0000_0100, 32'h0, 1'b0, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("t1_hit_nreq", nreq, 32'd0);
    chk("t1_hit_rd",   rd, 32'hDEAD_BEEF);

    // 2: byte store hitting the cached line, then reload from the merged line
    access(4'b0100, 32'h0000_0102, 32'h00AB_0000, 1'b0, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("t2_st_nreq", nreq, 32'd1);
    chk("t2_st_addr", maddr, 32'h0000_0102);
    chk("t2_st_size", {30'd0, msize}, 32'd0);
    chk("t2_st_wr",   {31'd0, mwr}, 32'd1);
    access(4'b0000, 32'h0000_0100, 32'h0, 1'b0, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("t2_ld_nreq", nreq, 32'd0);
    chk("t2_ld_rd",   rd, 32'hDEAB_BEEF);

    // 3: half store to a missing line is not allocated
    access(4'b1100, 32'h0000_2000, 32'h1234_0000, 1'b0, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("t3_st_addr", maddr, 32'h0000_2002);
    chk("t3_st_size", {30'd0, msize}, 32'd1);
    access(4'b0000, 32'h0000_2000, 32'h0, 1'b0, 0, 32'h1111_2222, rd, nreq, maddr, msize, mwr, stable);
    chk("t3_ld_nreq", nreq, 32'd1);
    chk("t3_ld_rd",   rd, 32'h1111_2222);

    // decoder corner cases, issued uncached so the arrays stay untouched
    access(4'b1000, 32'h0000_0100, 32'hAA00_0000, 1'b1, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("dec_b3_addr", maddr, 32'h0000_0103);
    chk("dec_b3_size", {30'd0, msize}, 32'd0);
    access(4'b0101, 32'h0000_0103, 32'h0055_0055, 1'b1, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("dec_odd_addr", maddr, 32'h0000_0100);
    chk("dec_odd_size", {30'd0, msize}, 32'd2);
    access(4'b0011, 32'h0000_0102, 32'h0000_5A5A, 1'b1, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("dec_h0_addr", maddr, 32'h0000_0100);
    chk("dec_h0_size", {30'd0, msize}, 32'd1);
    access(4'b0000, 32'h0000_0100, 32'h0, 1'b0, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("unc_st_keeps_line", rd, 32'hDEAB_BEEF);

    // 4: uncached loads with delayed acceptance, never filled
    access(4'b0000, 32'hBFAF_8000, 32'h0, 1'b1, 3, 32'hCAFE_F00D, rd, nreq, maddr, msize, mwr, stable);
    chk("t4_a_nreq",   nreq, 32'd1);
    chk("t4_a_addr",   maddr, 32'hBFAF_8000);
    chk("t4_a_stable", {31'd0, stable}, 32'd1);
    chk("t4_a_rd",     rd, 32'hCAFE_F00D);
    access(4'b0000, 32'hBFAF_8000, 32'h0, 1'b1, 3, 32'h0BAD_F00D, rd, nreq, maddr, msize, mwr, stable);
    chk("t4_b_nreq", nreq, 32'd1);
    chk("t4_b_rd",   rd, 32'h0BAD_F00D);
    access(4'b0000, 32'hBFAF_8000, 32'h0, 1'b0, 0, 32'h1357_9BDF, rd, nreq, maddr, msize, mwr, stable);
    chk("t4_nofill_nreq", nreq, 32'd1);

    // 5: conflict on index 0x40
    access(4'b0000, 32'h0000_0500, 32'h0, 1'b0, 0, 32'h5555_5555, rd, nreq, maddr, msize, mwr, stable);
    chk("t5_500_nreq", nreq, 32'd1);
    access(4'b0000, 32'h0000_0500, 32'h0, 1'b0, 0, 32'h0, rd, nreq, maddr, msize, mwr, stable);
    chk("t5_500_hit_nreq", nreq, 32'd0);
    chk("t5_500_hit_rd",   rd, 32'h5555_5555);
    access(4'b0000, 32'h0000_0100, 32'h0, 1'b0, 0, 32'hDEAB_BEEF, rd, nreq, maddr, msize, mwr, stable);
    chk("t5_100_nreq", nreq, 32'd1);
    chk("t5_100_rd",   rd, 32'hDEAB_BEEF);

    // 6: reset while in WAIT; a late data_ok must be ignored
    cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_0500; cpu_uncached = 1'b0;
    #1;
    chk("t6_stall_idle", {31'd0, cpu_stall}, 32'd1);
    @(negedge clk);
    #1;
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    #1;
    chk("t6_req_dropped", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_en = 1'b0;
    #1;
    chk("t6_rst_req",   {31'd0, mem_req},   32'd0);
    chk("t6_rst_stall", {31'd0, cpu_stall}, 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    chk("t6_late_req",   {31'd0, mem_req},   32'd0);
    chk("t6_late_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    access(4'b0000, 32'h0000_0100, 32'h0, 1'b0, 0, 32'h7777_7777, rd, nreq, maddr, msize, mwr, stable);
    chk("t6_cleared_nreq", nreq, 32'd1);
    chk("t6_cleared_rd",   rd, 32'h7777_7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
